// File: rtl/bitrev_reorder_pp.sv
// Ping-pong bit-reversal reorder buffer: FFT-order frames in, natural-order frames out.
// Optional REORDER_BYPASS_EN adds a per-frame `bypass` input for natural-order pass-through.
module bitrev_reorder_pp #(
  parameter int WIDTH = 18,
  parameter int LOG2N = 4
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef REORDER_BYPASS_EN
  input  logic                    bypass,
`endif
  input  logic signed [WIDTH-1:0] di_re,
  input  logic signed [WIDTH-1:0] di_im,
  input  logic                    di_en,
  output logic                    di_rdy,
  output logic signed [WIDTH-1:0] do_re,
  output logic signed [WIDTH-1:0] do_im,
  output logic                    do_en,
  output logic                    do_last,
  input  logic                    do_rdy
);

  localparam int N = 1 << LOG2N;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

  bank_state_t        state_q [2];
  bank_state_t        state_d [2];
  logic [LOG2N-1:0]   wr_cnt;
  logic [LOG2N-1:0]   rd_cnt;
  logic               wr_bank;
  logic               rd_bank;
  logic [LOG2N-1:0]   wr_addr;
  logic               wr_fire;
  logic               rd_load;
  logic               out_free;
  logic [2*WIDTH-1:0] mem [2*N];
  logic [2*WIDTH-1:0] rd_word_p0;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  assign di_rdy   = (state_q[wr_bank] == EMPTY) || (state_q[wr_bank] == FILLING);
  assign wr_fire  = di_en && di_rdy;
  assign out_free = !do_en || do_rdy;
  assign rd_load  = out_free &&
                    ((state_q[rd_bank] == FULL) || (state_q[rd_bank] == DRAINING));

`ifdef REORDER_BYPASS_EN
  // Bypass is latched on the first sample; that sample lands at address 0 either way.
  logic [1:0] byp_q;
  logic       byp_cur;

  assign byp_cur = (wr_cnt == '0) ? bypass : byp_q[wr_bank];
  assign wr_addr = byp_cur ? wr_cnt : bitrev(wr_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_q <= '0;
    end else if (wr_fire && (wr_cnt == '0)) begin
      byp_q[wr_bank] <= bypass;
    end
  end
`else
  assign wr_addr = bitrev(wr_cnt);
`endif

  // Write and read touch disjoint state sets, so one bank never sees both in a cycle.
  always_comb begin
    state_d[0] = state_q[0];
    state_d[1] = state_q[1];
    if (wr_fire) state_d[wr_bank] = (&wr_cnt) ? FULL : FILLING;
    if (rd_load) state_d[rd_bank] = (&rd_cnt) ? EMPTY : DRAINING;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      rd_cnt     <= '0;
      rd_bank    <= 1'b0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (&wr_cnt) wr_bank <= ~wr_bank;
      end
      if (rd_load) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (&rd_cnt) rd_bank <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_bank, wr_addr}] <= {di_re, di_im};
  end

  // Stage p0: asynchronous bank read at the linear read pointer
  assign rd_word_p0 = mem[{rd_bank, rd_cnt}];

  // Stage p1: output register; holds while stalled, zeroed when no sample is present
  always_ff @(posedge clk) begin
    if (rst) begin
      do_en   <= 1'b0;
      do_last <= 1'b0;
      do_re   <= '0;
      do_im   <= '0;
    end else if (out_free) begin
      if (rd_load) begin
        do_en   <= 1'b1;
        do_last <= &rd_cnt;
        do_re   <= $signed(rd_word_p0[2*WIDTH-1:WIDTH]);
        do_im   <= $signed(rd_word_p0[WIDTH-1:0]);
      end else begin
        do_en   <= 1'b0;
        do_last <= 1'b0;
        do_re   <= '0;
        do_im   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bitrev_reorder_pp.sv
// Directed bench for bitrev_reorder_pp: one LOG2N=4 instance and one LOG2N=3 instance.
// Outputs are collected at the falling edge and checked against hand-written order tables.
module tb_bitrev_reorder_pp;
  localparam int W = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic signed [W-1:0] di_re4, di_im4, do_re4, do_im4;
  logic di_en4, di_rdy4, do_en4, do_last4, do_rdy4;
  logic signed [W-1:0] di_re3, di_im3, do_re3, do_im3;
  logic di_en3, di_rdy3, do_en3, do_last3, do_rdy3;
`ifdef REORDER_BYPASS_EN
  logic bypass4, bypass3;
`endif

  bitrev_reorder_pp #(.WIDTH(W), .LOG2N(4)) dut4 (
    .clk(clk), .rst(rst),
`ifdef REORDER_BYPASS_EN
    .bypass(bypass4),
`endif
    .di_re(di_re4), .di_im(di_im4), .di_en(di_en4), .di_rdy(di_rdy4),
    .do_re(do_re4), .do_im(do_im4), .do_en(do_en4), .do_last(do_last4), .do_rdy(do_rdy4)
  );

  bitrev_reorder_pp #(.WIDTH(W), .LOG2N(3)) dut3 (
    .clk(clk), .rst(rst),
`ifdef REORDER_BYPASS_EN
    .bypass(bypass3),
`endif
    .di_re(di_re3), .di_im(di_im3), .di_en(di_en3), .di_rdy(di_rdy3),
    .do_re(do_re3), .do_im(do_im3), .do_en(do_en3), .do_last(do_last3), .do_rdy(do_rdy3)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int q4_re[$], q4_im[$], q4_last[$], q4_cyc[$];
  int q3_re[$], q3_im[$], q3_last[$];

  always @(negedge clk) begin
    if (do_en4 && do_rdy4) begin
      q4_re.push_back(do_re4);
      q4_im.push_back(do_im4);
      q4_last.push_back(int'(do_last4));
      q4_cyc.push_back(cyc);
    end
    if (do_en3 && do_rdy3) begin
      q3_re.push_back(do_re3);
      q3_im.push_back(do_im3);
      q3_last.push_back(int'(do_last3));
    end
  end

  int br4[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  int in3[8]  = '{-131072, 131071, -1, 0, 1, 2, 3, 4};
  int exp3[8] = '{-131072, 1, -1, 3, 131071, 2, 0, 4};

  int nvec = 0;
  int nfail = 0;
  int stalls = 0;
  int timeouts = 0;
  int last_in4 = 0;
  int held_changes = 0;
  int hold_re = 0;
  int hold_en = 0;
  int rdy_end = 1;
  int g = 0;
  int v = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send4(input int re, input int im);
    int guard;
    guard = 0;
    di_en4 = 1'b1;
    di_re4 = W'(re);
    di_im4 = W'(im);
    @(negedge clk);
    while (!di_rdy4 && guard < 300) begin
      stalls++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 300) timeouts++;
    last_in4 = cyc;
    @(posedge clk); #1;
    di_en4 = 1'b0;
  endtask

  task automatic send3(input int re, input int im);
    int guard;
    guard = 0;
    di_en3 = 1'b1;
    di_re3 = W'(re);
    di_im3 = W'(im);
    @(negedge clk);
    while (!di_rdy3 && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 300) timeouts++;
    @(posedge clk); #1;
    di_en3 = 1'b0;
  endtask

  task automatic wait4(input int n);
    int guard;
    guard = 0;
    while (q4_re.size() < n && guard < 400) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic clear4();
    q4_re.delete(); q4_im.delete(); q4_last.delete(); q4_cyc.delete();
  endtask

  initial begin
    rst = 1'b1;
    di_en4 = 1'b0; di_re4 = '0; di_im4 = '0; do_rdy4 = 1'b1;
    di_en3 = 1'b0; di_re3 = '0; di_im3 = '0; do_rdy3 = 1'b1;
`ifdef REORDER_BYPASS_EN
    bypass4 = 1'b0; bypass3 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_do_en", int'(do_en4), 0);
    chk("rst_do_re", int'(do_re4), 0);
    chk("rst_do_im", int'(do_im4), 0);
    chk("rst_do_last", int'(do_last4), 0);
    chk("rst_di_rdy", int'(di_rdy4), 1);
    chk("rst_do_en3", int'(do_en3), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_di_rdy", int'(di_rdy4), 1);
    @(posedge clk); #1;

    // single frame 0..15
    clear4();
    for (int k = 0; k < 16; k++) send4(k, -k);
    wait4(16);
    chk("single_count", q4_re.size(), 16);
    if (q4_re.size() >= 16) begin
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("single_re[%0d]", k), q4_re[k], br4[k]);
        chk($sformatf("single_im[%0d]", k), q4_im[k], -br4[k]);
        chk($sformatf("single_last[%0d]", k), q4_last[k], (k == 15) ? 1 : 0);
      end
      chk("single_latency", q4_cyc[0], last_in4 + 2);
      chk("single_span", q4_cyc[15] - q4_cyc[0], 15);
    end
    repeat (3) @(negedge clk);
    chk("idle_do_en", int'(do_en4), 0);
    chk("idle_do_re", int'(do_re4), 0);
    chk("idle_do_last", int'(do_last4), 0);
    @(posedge clk); #1;

    // three back-to-back frames
    clear4();
    stalls = 0;
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 16; k++) send4(200 + 16 * f + k, -(200 + 16 * f + k));
    chk("b2b_no_stall", stalls, 0);
    wait4(48);
    chk("b2b_count", q4_re.size(), 48);
    if (q4_re.size() >= 48) begin
      for (int i = 0; i < 48; i++) begin
        chk($sformatf("b2b_re[%0d]", i), q4_re[i], 200 + 16 * (i / 16) + br4[i % 16]);
        chk($sformatf("b2b_last[%0d]", i), q4_last[i], ((i % 16) == 15) ? 1 : 0);
      end
      chk("b2b_gapfree", q4_cyc[47] - q4_cyc[0], 47);
    end
    @(posedge clk); #1;

    // backpressure: 40-cycle stall during frame 0 output
    clear4();
    stalls = 0;
    held_changes = 0;
    fork
      begin
        for (int f = 0; f < 3; f++)
          for (int k = 0; k < 16; k++) send4(400 + 16 * f + k, -(400 + 16 * f + k));
      end
      begin
        g = 0;
        while (q4_re.size() < 3 && g < 200) begin
          @(negedge clk);
          g++;
        end
        @(posedge clk); #1;
        do_rdy4 = 1'b0;
        @(negedge clk);
        hold_re = do_re4;
        hold_en = int'(do_en4);
        repeat (39) begin
          @(negedge clk);
          if (do_re4 !== W'(hold_re) || do_en4 !== 1'b1) held_changes++;
        end
        rdy_end = int'(di_rdy4);
        @(posedge clk); #1;
        do_rdy4 = 1'b1;
      end
    join
    chk("bp_hold_en", hold_en, 1);
    chk("bp_hold_stable", held_changes, 0);
    chk("bp_di_rdy_low", rdy_end, 0);
    chk("bp_stalled", (stalls > 0) ? 1 : 0, 1);
    wait4(48);
    repeat (5) @(negedge clk);
    chk("bp_count", q4_re.size(), 48);
    if (q4_re.size() >= 48) begin
      for (int i = 0; i < 48; i++) begin
        chk($sformatf("bp_re[%0d]", i), q4_re[i], 400 + 16 * (i / 16) + br4[i % 16]);
        chk($sformatf("bp_im[%0d]", i), q4_im[i], -(400 + 16 * (i / 16) + br4[i % 16]));
        chk($sformatf("bp_last[%0d]", i), q4_last[i], ((i % 16) == 15) ? 1 : 0);
      end
    end
    @(posedge clk); #1;

    // mid-frame reset after 7 samples, then a full frame 100..115
    clear4();
    for (int k = 0; k < 7; k++) send4(50 + k, -(50 + k));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_di_rdy", int'(di_rdy4), 1);
    chk("midrst_do_en", int'(do_en4), 0);
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) send4(100 + k, -(100 + k));
    wait4(16);
    repeat (5) @(negedge clk);
    chk("midrst_count", q4_re.size(), 16);
    if (q4_re.size() >= 16) begin
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("midrst_re[%0d]", k), q4_re[k], 100 + br4[k]);
        chk($sformatf("midrst_last[%0d]", k), q4_last[k], (k == 15) ? 1 : 0);
      end
    end
    @(posedge clk); #1;

    // signed extremes, LOG2N=3
    for (int k = 0; k < 8; k++) begin
      v = in3[k];
      send3(v, ~v);
    end
    g = 0;
    while (q3_re.size() < 8 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("n8_count", q3_re.size(), 8);
    if (q3_re.size() >= 8) begin
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("n8_re[%0d]", k), q3_re[k], exp3[k]);
        chk($sformatf("n8_im[%0d]", k), q3_im[k], ~exp3[k]);
        chk($sformatf("n8_last[%0d]", k), q3_last[k], (k == 7) ? 1 : 0);
      end
    end
    @(posedge clk); #1;

`ifdef REORDER_BYPASS_EN
    // bypass frame then reordered frame
    clear4();
    bypass4 = 1'b1;
    for (int k = 0; k < 16; k++) send4(k, -k);
    bypass4 = 1'b0;
    for (int k = 0; k < 16; k++) send4(k, -k);
    wait4(32);
    chk("byp_count", q4_re.size(), 32);
    if (q4_re.size() >= 32) begin
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("byp_on_re[%0d]", k), q4_re[k], k);
        chk($sformatf("byp_off_re[%0d]", k), q4_re[16 + k], br4[k]);
      end
    end
`endif

    chk("wait_timeouts", timeouts, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
